// File: rtl/dpll_freq_acq.sv
// Coarse frequency acquisition for the DPLL: a SAR search of the DCO control word
// driven by the summed TDC phase error, followed by phase-lock detection while tracking.
module dpll_freq_acq #(
  parameter int unsigned WIDTH      = 13,
  parameter int unsigned WIN        = 16,
  parameter int unsigned SETTLE_CYC = 4,
  parameter int unsigned LOCK_TH    = 1,
  parameter int unsigned LOCK_CNT   = 64,
  parameter int unsigned UNLOCK_CNT = 4
) (
  input  logic             clk,
  input  logic             resetb,
  input  logic             start,
  input  logic [3:0]       terr,
  output logic [WIDTH-1:0] dctrl,
  output logic             lf_reset,
  output logic             acq_busy,
  output logic             acq_done,
  output logic             locked
);

  localparam int unsigned ACC_W   = 4 + $clog2(WIN);
  localparam int unsigned CNT_MAX = (WIN > SETTLE_CYC) ? WIN : SETTLE_CYC;
  localparam int unsigned CNT_W   = $clog2(CNT_MAX);
  localparam int unsigned BIT_W   = $clog2(WIDTH);
  localparam int unsigned LCK_W   = $clog2(LOCK_CNT + 1);
  localparam int unsigned BAD_W   = $clog2(UNLOCK_CNT + 1);

  localparam logic [WIDTH-1:0] MID_WORD = {1'b1, {(WIDTH-1){1'b0}}};

  localparam logic [2:0] IDLE   = 3'd0;
  localparam logic [2:0] SETTLE = 3'd1;
  localparam logic [2:0] ACCUM  = 3'd2;
  localparam logic [2:0] DECIDE = 3'd3;
  localparam logic [2:0] TRACK  = 3'd4;

  logic [2:0]       state, state_n;
  logic             start_q;
  logic [WIDTH-1:0] dctrl_n;
  logic [ACC_W-1:0] acc, acc_n;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic [BIT_W-1:0] bit_idx, bit_n;
  logic [LCK_W-1:0] lock_cnt, lock_n, lock_inc;
  logic [BAD_W-1:0] bad_cnt, bad_n;
  logic             locked_n;
  logic [ACC_W-1:0] terr_ext;
  logic [4:0]       terr_mag;
  logic             good;

  // Sign-extended error for the accumulator and its magnitude for the lock window
  assign terr_ext = {{(ACC_W-4){terr[3]}}, terr};
  assign terr_mag = terr[3] ? (5'd16 - {1'b0, terr}) : {1'b0, terr};
  assign good     = (terr_mag <= 5'(LOCK_TH));
  assign lock_inc = (lock_cnt == LCK_W'(LOCK_CNT)) ? lock_cnt : lock_cnt + 1'b1;

  always_comb begin
    state_n  = state;
    dctrl_n  = dctrl;
    acc_n    = acc;
    cnt_n    = cnt;
    bit_n    = bit_idx;
    lock_n   = lock_cnt;
    bad_n    = bad_cnt;
    locked_n = locked;
    if (start_q && (state == IDLE || state == TRACK)) begin
      state_n  = SETTLE;
      bit_n    = BIT_W'(WIDTH - 1);
      dctrl_n  = MID_WORD;
      cnt_n    = '0;
      lock_n   = '0;
      bad_n    = '0;
      locked_n = 1'b0;
    end else begin
      case (state)
        SETTLE: begin
          if (cnt == CNT_W'(SETTLE_CYC - 1)) begin
            state_n = ACCUM;
            cnt_n   = '0;
            acc_n   = '0;
          end else begin
            cnt_n = cnt + 1'b1;
          end
        end
        ACCUM: begin
          acc_n = acc + terr_ext;
          if (cnt == CNT_W'(WIN - 1)) begin
            state_n = DECIDE;
            cnt_n   = '0;
          end else begin
            cnt_n = cnt + 1'b1;
          end
        end
        DECIDE: begin
          // Negative sum means the DCO is too fast: drop the trial bit
          if (acc[ACC_W-1]) dctrl_n[bit_idx] = 1'b0;
          if (bit_idx != '0) begin
            bit_n                    = bit_idx - 1'b1;
            dctrl_n[bit_idx - 1'b1]  = 1'b1;
            state_n                  = SETTLE;
          end else begin
            state_n = TRACK;
          end
        end
        TRACK: begin
          if (!locked) begin
            if (good) begin
              lock_n = lock_inc;
              if (lock_inc == LCK_W'(LOCK_CNT)) locked_n = 1'b1;
            end else begin
              lock_n = '0;
            end
          end else if (good) begin
            lock_n = lock_inc;
            bad_n  = '0;
          end else if (bad_cnt == BAD_W'(UNLOCK_CNT - 1)) begin
            locked_n = 1'b0;
            lock_n   = '0;
            bad_n    = '0;
          end else begin
            bad_n = bad_cnt + 1'b1;
          end
        end
        IDLE:    state_n = IDLE;
        default: state_n = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge resetb) begin
    if (!resetb) begin
      state    <= IDLE;
      start_q  <= 1'b0;
      dctrl    <= MID_WORD;
      acc      <= '0;
      cnt      <= '0;
      bit_idx  <= '0;
      lock_cnt <= '0;
      bad_cnt  <= '0;
      locked   <= 1'b0;
      lf_reset <= 1'b1;
      acq_busy <= 1'b0;
      acq_done <= 1'b0;
    end else begin
      state    <= state_n;
      start_q  <= start;
      dctrl    <= dctrl_n;
      acc      <= acc_n;
      cnt      <= cnt_n;
      bit_idx  <= bit_n;
      lock_cnt <= lock_n;
      bad_cnt  <= bad_n;
      locked   <= locked_n;
      lf_reset <= (state_n != TRACK);
      acq_busy <= (state_n == SETTLE) || (state_n == ACCUM) || (state_n == DECIDE);
      acq_done <= (state_n == TRACK);
    end
  end

endmodule

// File: doc/dpll_freq_acq.md
# dpll_freq_acq

Coarse frequency-acquisition and lock-detect controller for the digital PLL. It sits beside the digital loop filter on the feedback-clock side of the loop. It reads the signed TDC phase-error code and runs a 13-bit successive-approximation search on the DCO control word while holding the loop filter in reset. It then releases the filter with the found word as its starting point and reports phase lock from the same TDC stream.

## Interface
- WIDTH, 13: DCO control word width
- WIN, 16: TDC samples accumulated per SAR decision; power of 2, 2..64
- SETTLE_CYC, 4: wait cycles after each control-word change before accumulating; ≥1
- LOCK_TH, 1: lock window; a sample is good when |terr| ≤ LOCK_TH
- LOCK_CNT, 64: consecutive good samples required to assert locked
- UNLOCK_CNT, 4: consecutive bad samples required to drop locked
- clk  input  1  feedback clock (divided DCO clock, bit domain); all logic on rising edge
- resetb  input  1  asynchronous, active-low reset
- start  input  1  acquisition request, sampled each edge
- terr  input  4  signed TDC phase error; positive means feedback lags reference, so DCO too slow
- dctrl  output  WIDTH  DCO control word / loop-filter initial value
- lf_reset  output  1  active-high hold for the loop filter; 1 except in TRACK
- acq_busy  output  1  high in SETTLE, ACCUM and DECIDE
- acq_done  output  1  high in TRACK
- locked  output  1  phase-lock indication, valid only in TRACK

## Operation
- Reset: state IDLE; dctrl = 1<<(WIDTH-1) = 0x1000; lf_reset = 1; acq_busy = acq_done = locked = 0; accumulator, bit index and lock counters = 0.
- FSM states: IDLE, SETTLE, ACCUM, DECIDE, TRACK.
- IDLE: when start = 1, go to SETTLE with bit index = WIDTH-1 and dctrl = 0x1000.
- SETTLE: hold for SETTLE_CYC cycles, then go to ACCUM with the accumulator cleared.
- ACCUM: add sign-extended terr every cycle for WIN cycles. The accumulator is 4+log2(WIN) bits signed, so it cannot overflow. Then go to DECIDE.
- DECIDE (1 cycle):
  - If sum ≥ 0, keep the trial bit; otherwise clear it.
  - If the bit index > 0, decrement the index, set the next-lower bit in dctrl and go to SETTLE.
  - If the bit index is 0, go to TRACK.
- TRACK:
  - dctrl is frozen; lf_reset = 0; acq_done = 1.
  - Lock counter: increments on each good sample and saturates at LOCK_CNT. A bad sample clears it while unlocked.
  - locked rises on the edge where the good count reaches LOCK_CNT.
  - While locked, a separate bad-run counter increments on each bad sample and clears on each good sample. When it reaches UNLOCK_CNT, locked falls and both counters clear.
  - terr = -8 has magnitude 8.
- start while acq_busy: ignored.
- start in TRACK: clear locked and acq_done, set lf_reset = 1, restart from SETTLE exactly as from IDLE.
- resetb low at any time, including mid-ACCUM: immediate return to the reset values. There is no resume; a new start is required.

## Timing
- All outputs are registered and change only on clk rising edges, except under asynchronous reset.
- Per-bit cost: SETTLE_CYC + WIN + 1 = 21 cycles.
- Full search: 13 × 21 = 273 cycles.
- dctrl update: the new trial word appears on the edge leaving DECIDE, so the DCO sees it for the full SETTLE+ACCUM window.
- acq_busy: rises on the edge after start is sampled.
- acq_done and lf_reset: acq_done rises and lf_reset falls 274 edges after the edge that sampled start. acq_busy falls on the same edge.
- locked latency: earliest at the LOCK_CNT-th consecutive good sample in TRACK (64 edges after TRACK entry). Samples taken before TRACK do not count.

## Test plan
- Reset check: assert resetb = 0 mid-ACCUM of bit 7 -> outputs return immediately to dctrl = 0x1000, lf_reset = 1, all flags 0. After release with no start, the block stays idle.
- SAR convergence: behavioural DCO gives terr = +2 when dctrl ≤ 0x0A5C, else −2; pulse start -> dctrl = 0x0A5C and acq_done rises exactly 274 edges after start.
- Extremes: constant terr = 0 -> dctrl = 0x1FFF; constant terr = −1 -> dctrl = 0x0000; constant terr = −8 -> 0x0000 with no accumulator overflow.
- Lock assert: in TRACK, 63 samples of terr = 1 then terr = 2 -> locked stays 0. Then 64 samples of terr = −1 -> locked rises on the 64th.
- Unlock hysteresis: while locked, feed 3 × terr = 3, 1 × terr = 0, then 4 × terr = −3 -> locked stays 1 through the first 3 bad samples and falls on the 4th bad of the final run.
- Start handling: start pulse during ACCUM -> ignored, final dctrl unchanged. Start pulse in TRACK while locked -> locked and acq_done fall, lf_reset = 1, dctrl = 0x1000 on the next edge, and a full new search follows.
